// File: rtl/mine_game_ctrl.sv
// mine_game_ctrl: game-flow controller for Mine Quest.
// Sequences the game timer (timer_resetn / is_game_over), accepts reveal events
// from the board, counts distinct safe cells revealed and declares win or loss.
// Ports:
//   CLOCK_50, resetn          clock, async active-low reset
//   start_btn, pause_btn      debounced synchronous button levels (edge detected here)
//   reveal_valid/_is_mine/_is_new  reveal pulse and its qualifiers
//   reveal_ready              board may pulse reveal_valid only while high
//   timer_resetn, is_game_over  game timer controls
//   game_won, game_lost, state, safe_revealed  status for display logic
// All outputs are registered.
module mine_game_ctrl #(
  parameter int TOTAL_CELLS = 64,
  parameter int NUM_MINES   = 10,
  parameter int CW          = 7
) (
  input  logic          CLOCK_50,
  input  logic          resetn,
  input  logic          start_btn,
  input  logic          pause_btn,
  input  logic          reveal_valid,
  input  logic          reveal_is_mine,
  input  logic          reveal_is_new,
  output logic          reveal_ready,
  output logic          timer_resetn,
  output logic          is_game_over,
  output logic          game_won,
  output logic          game_lost,
  output logic [2:0]    state,
  output logic [CW-1:0] safe_revealed
);
  localparam int SAFE_CELLS = TOTAL_CELLS - NUM_MINES;
  localparam logic [CW-1:0] SAFE_C = CW'(SAFE_CELLS);

  typedef enum logic [2:0] {
    IDLE = 3'd0, CLEAR = 3'd1, ARMED = 3'd2, PLAYING = 3'd3,
    PAUSED = 3'd4, WON = 3'd5, LOST = 3'd6
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          start_q, pause_q;
  logic          start_rise, pause_rise;
  logic          reveal_ready_q, reveal_ready_d;
  logic          timer_resetn_q, timer_resetn_d;
  logic          is_game_over_q, is_game_over_d;
  logic          game_won_q, game_won_d;
  logic          game_lost_q, game_lost_d;

  always_comb begin
    start_rise = start_btn & ~start_q;
    pause_rise = pause_btn & ~pause_q;
    cnt_inc    = cnt_q + CW'(1);
    state_d    = state_q;
    cnt_d      = cnt_q;
    if (start_rise) begin
      // Restart wins over everything; the count is zeroed as CLEAR is entered
      // so the CLEAR cycle already shows a fresh board.
      state_d = CLEAR;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE:  state_d = IDLE;
        CLEAR: state_d = ARMED;
        ARMED, PLAYING: begin
          if (reveal_valid && reveal_is_mine) begin
            state_d = LOST;
          end else if (reveal_valid && reveal_is_new) begin
            if (cnt_q != SAFE_C) cnt_d = cnt_inc;
            state_d = (cnt_inc == SAFE_C) ? WON : PLAYING;
          end else if (state_q == PLAYING && pause_rise) begin
            // an effective reveal in the same cycle takes precedence over pause
            state_d = PAUSED;
          end
        end
        PAUSED:   if (pause_rise) state_d = PLAYING;
        WON, LOST: state_d = state_q;
        default:  state_d = IDLE;
      endcase
    end
    // Outputs are a registered decode of the next state.
    timer_resetn_d = !(state_d == IDLE || state_d == CLEAR);
    is_game_over_d = (state_d != PLAYING);
    reveal_ready_d = (state_d == ARMED || state_d == PLAYING);
    game_won_d     = (state_d == WON);
    game_lost_d    = (state_d == LOST);
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      // history starts high so a button held through reset gives no edge
      start_q        <= 1'b1;
      pause_q        <= 1'b1;
      reveal_ready_q <= 1'b0;
      timer_resetn_q <= 1'b0;
      is_game_over_q <= 1'b1;
      game_won_q     <= 1'b0;
      game_lost_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      start_q        <= start_btn;
      pause_q        <= pause_btn;
      reveal_ready_q <= reveal_ready_d;
      timer_resetn_q <= timer_resetn_d;
      is_game_over_q <= is_game_over_d;
      game_won_q     <= game_won_d;
      game_lost_q    <= game_lost_d;
    end
  end

  assign state         = state_q;
  assign safe_revealed = cnt_q;
  assign reveal_ready  = reveal_ready_q;
  assign timer_resetn  = timer_resetn_q;
  assign is_game_over  = is_game_over_q;
  assign game_won      = game_won_q;
  assign game_lost     = game_lost_q;
endmodule

// File: doc/mine_game_ctrl.md
Name: mine_game_ctrl

Overview:
Top-level game-flow controller for Mine Quest. It sequences the game timer by driving its sync reset and its is_game_over run/stop input. It accepts reveal events from the board logic, counts newly revealed safe cells, and declares win or loss. Pause and restart come from debounced, CLOCK_50-synchronous push-button levels.

Parameters:
TOTAL_CELLS, 64, number of cells on the board
NUM_MINES, 10, number of mines; SAFE_CELLS = TOTAL_CELLS - NUM_MINES (must be >= 1)
CW, 7, counter width; must satisfy 2^CW > TOTAL_CELLS

Ports:
CLOCK_50  in  1  system clock, 50 MHz
resetn  in  1  asynchronous active-low reset
start_btn  in  1  restart button level, sync, debounced, active-high
pause_btn  in  1  pause toggle button level, sync, debounced, active-high
reveal_valid  in  1  one-cycle pulse: board reports a reveal
reveal_is_mine  in  1  qualifies reveal_valid: revealed cell holds a mine
reveal_is_new  in  1  qualifies reveal_valid: cell was previously hidden
reveal_ready  out  1  high only in ARMED/PLAYING; board must not pulse reveal_valid otherwise
timer_resetn  out  1  to game timer sync reset, active-low
is_game_over  out  1  to game timer; 0 = timer runs
game_won  out  1  high in WON
game_lost  out  1  high in LOST
state  out  3  encoded state, for display logic
safe_revealed  out  CW  count of distinct safe cells revealed this game

Behaviour:
- All outputs are registered. Every output changes the cycle after the triggering sample.
- Async reset values:
  - state=IDLE, timer_resetn=0, is_game_over=1, game_won=0, game_lost=0, reveal_ready=0, safe_revealed=0.
  - Edge-detect history registers reset to 1, so a button held through reset produces no edge.
- Edge detect: start_rise = start_btn & ~start_q, where start_q is the prior-cycle sample. pause_rise is formed the same way.
- State encoding: IDLE=0, CLEAR=1, ARMED=2, PLAYING=3, PAUSED=4, WON=5, LOST=6.
- Priority when events coincide in one cycle: start_rise > reveal > pause_rise.
  - start_rise in any state -> CLEAR (restart), and any reveal in that cycle is dropped.
- Transitions:
  - IDLE: timer held in reset. start_rise -> CLEAR.
  - CLEAR (exactly 1 cycle): timer_resetn=0, safe_revealed<=0, game_won/lost<=0 -> ARMED.
  - ARMED: timer_resetn=1, is_game_over=1 (timer frozen at 00:00:00). Clock starts on the first click:
    - reveal of a mine -> LOST.
    - new safe reveal -> increment count, then PLAYING, or WON if SAFE_CELLS==1.
    - pause ignored.
  - PLAYING: is_game_over=0.
    - new safe reveal -> count+1; if count+1 == SAFE_CELLS -> WON.
    - mine -> LOST.
    - pause_rise -> PAUSED.
  - PAUSED: is_game_over=1, reveal_ready=0, reveals ignored. pause_rise -> PLAYING.
  - WON / LOST: is_game_over=1 (timer holds final time), reveal_ready=0. Only start_rise leaves.
- Reveals with reveal_is_new=0 and reveal_is_mine=0 are no-ops; the count never double-counts.
- A mine reveal takes effect regardless of reveal_is_new.
- safe_revealed saturates at SAFE_CELLS; reaching it always coincides with entering WON.
- Any reveal_valid outside ARMED/PLAYING is ignored with no state or count change.
- Async reset mid-game returns to IDLE immediately; the timer is re-cleared through timer_resetn=0.
- Unused encodings (7) -> IDLE on the next clock.

Test Plan:
- Reset, then start_btn 0->1 -> state IDLE->CLEAR (1 cycle, timer_resetn=0) -> ARMED. is_game_over=1 and the timer stays at 0.
- TOTAL_CELLS=16, NUM_MINES=3: 13 new safe reveals -> state PLAYING after the 1st reveal. After the 13th reveal: state=WON, game_won=1, is_game_over=1, safe_revealed=13.
- In PLAYING, safe_revealed=5: mine reveal -> state LOST, game_lost=1, safe_revealed stays 5. Further reveals ignored.
- In PLAYING, pause_rise -> PAUSED, is_game_over=1, reveal_ready=0. A reveal pulse there changes nothing. Second pause_rise -> PLAYING.
- Same cycle start_rise + mine reveal in PLAYING -> CLEAR, not LOST. Same cycle mine reveal + pause_rise -> LOST.
- Repeat reveal (reveal_is_new=0, safe) 3 times -> safe_revealed unchanged. Assert resetn=0 mid-PLAYING -> immediate IDLE, timer_resetn=0, count=0.
